// File: rtl/rsa_decrypt_ladder_if.sv
// Start/finish handshake and operand bus of the RSA decryption ladder.
// The master issues requests; the slave (the engine) returns the message.
interface rsa_decrypt_ladder_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2*WIDTH-1:0]   c;
  logic [2*WIDTH-1:0]   d;
  logic [2*WIDTH-1:0]   n;
  logic [2*WIDTH-1:0]   m;
  logic                 finish;
  logic                 busy;

  modport master (output start, c, d, n, input m, finish, busy);
  modport slave  (input start, c, d, n, output m, finish, busy);
endinterface

// File: rtl/rsa_decrypt_ladder.sv
// Constant-time m = c^d mod n: Montgomery ladder over every exponent bit,
// built on two interleaved shift-add modular multipliers that always run.
module rsa_decrypt_ladder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rsa_decrypt_ladder_if.slave  bus
);
  localparam int K  = 2 * WIDTH;
  localparam int AW = K + 2;
  localparam int CW = $clog2(K + 1);
  localparam int IW = $clog2(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K);
  localparam logic [IW-1:0] IDX_TOP  = IW'(K - 1);

  typedef enum logic [1:0] {IDLE, INIT, LADDER, DONE} state_t;

  state_t         state_q, state_d;
  logic [K-1:0]   c_q, d_q, n_q;
  logic [K-1:0]   r0_q, r1_q;
  logic [K-1:0]   xa_q, ya_q, xb_q, yb_q;
  logic [AW-1:0]  acc_a_q, acc_b_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic           last_q, route_init_q, route_b_q;
  logic [K-1:0]   m_q;
  logic           finish_q, busy_q;

  logic           accept, load, step, wb, b_now;
  logic [K-1:0]   r0_eff, r1_eff, op_xa, op_ya, op_xb, op_yb;

  // One multiplier step; both reductions are always computed, muxes pick.
  function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc,
                                             input logic [K-1:0]  x,
                                             input logic          y_msb,
                                             input logic [K-1:0]  modn);
    logic [AW-1:0] s, t, u, nn;
    nn = {2'b00, modn};
    s  = (acc << 1) + (y_msb ? {2'b00, x} : '0);
    t  = (s >= nn) ? s - nn : s;
    u  = (t >= nn) ? t - nn : t;
    return u;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    wb      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        load = (cnt_q == '0);
        step = (cnt_q != '0);
        if (cnt_q == CNT_LAST) state_d = LADDER;
      end
      LADDER: begin
        // The load cycle of each round also retires the previous round.
        wb   = (cnt_q == '0);
        load = wb && !last_q;
        step = (cnt_q != '0);
        if (wb && last_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r0_eff = r0_q;
    r1_eff = r1_q;
    if (wb) begin
      if (route_init_q) begin
        r1_eff = acc_a_q[K-1:0];
      end else if (route_b_q) begin
        r0_eff = acc_a_q[K-1:0];
        r1_eff = acc_b_q[K-1:0];
      end else begin
        r0_eff = acc_b_q[K-1:0];
        r1_eff = acc_a_q[K-1:0];
      end
    end
    b_now = d_q[idx_q];
    if (state_q == INIT) begin
      // Unit B repeats unit A's reduction of c as a dummy workload.
      op_xa = K'(1);
      op_ya = c_q;
      op_xb = K'(1);
      op_yb = c_q;
    end else begin
      op_xa = r0_eff;
      op_ya = r1_eff;
      op_xb = b_now ? r1_eff : r0_eff;
      op_yb = b_now ? r1_eff : r0_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q          <= '0;
      d_q          <= '0;
      n_q          <= '0;
      r0_q         <= '0;
      r1_q         <= '0;
      xa_q         <= '0;
      ya_q         <= '0;
      xb_q         <= '0;
      yb_q         <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      route_init_q <= 1'b0;
      route_b_q    <= 1'b0;
      m_q          <= '0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (accept) begin
        c_q          <= bus.c;
        d_q          <= bus.d;
        n_q          <= bus.n;
        r0_q         <= K'(1);
        r1_q         <= '0;
        cnt_q        <= '0;
        idx_q        <= IDX_TOP;
        last_q       <= 1'b0;
        route_init_q <= 1'b1;
        route_b_q    <= 1'b0;
        busy_q       <= 1'b1;
      end
      if (wb) begin
        r0_q <= r0_eff;
        r1_q <= r1_eff;
      end
      if (load) begin
        acc_a_q <= '0;
        acc_b_q <= '0;
        xa_q    <= op_xa;
        ya_q    <= op_ya;
        xb_q    <= op_xb;
        yb_q    <= op_yb;
        cnt_q   <= CW'(1);
        if (state_q == LADDER) begin
          route_init_q <= 1'b0;
          route_b_q    <= b_now;
        end
      end
      if (step) begin
        acc_a_q <= mm_step(acc_a_q, xa_q, ya_q[K-1], n_q);
        acc_b_q <= mm_step(acc_b_q, xb_q, yb_q[K-1], n_q);
        ya_q    <= ya_q << 1;
        yb_q    <= yb_q << 1;
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          if (state_q == LADDER) begin
            if (idx_q == '0) last_q <= 1'b1;
            else             idx_q  <= idx_q - 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (wb && last_q) begin
        m_q      <= (n_q < K'(2)) ? '0 : r0_eff;
        finish_q <= 1'b1;
      end
      if (state_q == DONE) begin
        finish_q <= 1'b0;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.m      = m_q;
  assign bus.finish = finish_q;
  assign bus.busy   = busy_q;
endmodule

// File: doc/rsa_decrypt_ladder.md
Name: rsa_decrypt_ladder

Overview:
- Constant-time RSA decryption engine. Computes m = c^d mod n with a Montgomery ladder over all 2*WIDTH exponent bits, most significant bit first.
- Every run takes the same number of cycles, whatever the values of c, d and n. This protects the private exponent against timing side channels.
- Sits opposite the encrypt engine in the secure_modules set. It consumes the ciphertext that engine produces and uses the same start/finish handshake.

Parameters:
WIDTH, 8, half operand width; c, d, n and m are 2*WIDTH bits wide. K = 2*WIDTH throughout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
c  input  2*WIDTH  ciphertext; any value, including values >= n
d  input  2*WIDTH  private exponent
n  input  2*WIDTH  modulus
m  output  2*WIDTH  decrypted message; registered, held until the next accepted start
finish  output  1  one-cycle pulse; m is valid from this cycle
busy  output  1  high from the accepted start until the finish pulse, inclusive

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, m=0, finish=0, busy=0, all internal registers cleared. Reset in the middle of a run aborts it immediately; no finish pulse is produced.
- States: IDLE -> INIT -> LADDER -> DONE -> IDLE.
- IDLE to INIT:
  - Transition happens on an edge where start=1.
  - On that edge c, d and n are latched and busy is set.
  - start in any other state is ignored; the latched operands are not disturbed.
- Modular multiply unit (two identical instances, A and B):
  - Interleaved shift-add computing x*y mod n.
  - A round is K+1 cycles: one load cycle, then K step cycles, scanning y from MSB to LSB.
  - Each step: acc = 2*acc + (y_bit ? x : 0), then subtract n if acc >= n, then subtract n again if acc >= n.
  - The accumulator is K+2 bits wide. Invariant: acc < n after each step, provided x < n.
  - Both subtract comparisons are evaluated every step. Only muxes select the result.
- INIT (one round):
  - Unit A computes R1 = 1 * c mod n. This reduces c, so c >= n needs no special handling.
  - Unit B also runs this round with dummy operands, so power and timing stay uniform.
  - R0 is set to 1.
- LADDER (K rounds; bit counter runs K-1 down to 0; b = d[i]):
  - b=0: R1 <- R0*R1 (unit A), R0 <- R0*R0 (unit B).
  - b=1: R0 <- R0*R1 (unit A), R1 <- R1*R1 (unit B).
  - Operand and result routing is a mux on b. Both units always run a full round.
  - Leading zero bits of d are processed like any other bit; no early exit.
- DONE (1 cycle): m <- R0, finish=1, busy then drops, return to IDLE.
- Latency:
  - Start is accepted at edge 0.
  - finish is high in the cycle following edge L = (K+1)*(K+1) + 1.
  - WIDTH=8 gives L = 290.
  - L is fixed for all c, d and n values.
- Degenerate inputs:
  - n < 2: m = 0, with the same latency L. The full schedule runs; the result is forced at DONE.
  - d = 0: m = 1 for n >= 2.
  - c mod n = 0 with d > 0: m = 0.
- Start in the same cycle as the finish pulse: ignored, because the block is still in DONE. A start one cycle later is accepted.

Test Plan:
- WIDTH=8, n=3233, d=2753, c=2790, start pulse -> finish exactly 290 cycles after the start edge, m=65; m holds 65 until the next start.
- Same n and c, with d=1 and then d=65535 -> both finish at cycle 290 (zero latency difference). m=2790 for d=1; m matches the reference model for d=65535.
- c=6023 (= 2790 + n), n=3233, d=2753 -> m=65. d=0 -> m=1. c=0, d=5 -> m=0.
- n=1 and n=0, c=5, d=3 -> m=0, finish at cycle 290.
- Start asserted at cycle 100 of a run with different operands -> ignored; original result returned at cycle 290, and busy stays high throughout.
- rst_n dropped at cycle 150, then released, then a new start -> no finish from the aborted run; m=0 after reset; the new run finishes 290 cycles after its own start with the correct value.
